// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for ID-stage hazard detection on the 5-stage MIPS pipeline.
// Define HAZARD_FWD_EN when EX forwarding exists; without it every consumer waits for writeback.
module hazard_scoreboard #(
    parameter int NB_REG_ADDR = 5,
    parameter int LOAD_LAT    = 1,
    parameter int WB_DIST     = 2,
    parameter int NB_PERF     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_halt,
    input  logic                      i_id_valid,
    input  logic [NB_REG_ADDR-1:0]    i_id_rs,
    input  logic [NB_REG_ADDR-1:0]    i_id_rt,
    input  logic                      i_id_use_rs,
    input  logic                      i_id_use_rt,
    input  logic                      i_id_early,
    input  logic                      i_id_wr_en,
    input  logic [NB_REG_ADDR-1:0]    i_id_rd,
    input  logic                      i_id_is_load,
    input  logic                      i_kill,
    output logic                      o_stall_pc,
    output logic                      o_stall_ifid,
    output logic                      o_bubble_ex,
    output logic [2**NB_REG_ADDR-1:0] o_busy,
    output logic [NB_PERF-1:0]        o_stall_cnt
);
    localparam int NREG = 2 ** NB_REG_ADDR;
`ifdef HAZARD_FWD_EN
    localparam int ALU_VAL = 1;
    localparam int LD_VAL  = LOAD_LAT + 1;
    localparam int FWD_T   = 1;
`else
    localparam int ALU_VAL = WB_DIST;
    localparam int LD_VAL  = WB_DIST + LOAD_LAT - 1;
    localparam int FWD_T   = 0;
`endif
    localparam int MAX_VAL = (LD_VAL > ALU_VAL) ? LD_VAL : ALU_VAL;
    localparam int CW      = $clog2(MAX_VAL + 1);

    localparam logic [CW-1:0] ALU_C = CW'(ALU_VAL);
    localparam logic [CW-1:0] LD_C  = CW'(LD_VAL);
    localparam logic [CW-1:0] FWD_C = CW'(FWD_T);

    logic [CW-1:0]      cnt_q [NREG];
    logic [CW-1:0]      cnt_d [NREG];
    logic [NB_PERF-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]      thr;
    logic               rs_haz, rt_haz, stall, stall_out, issue;

    // Hazards look only at registered counters, so an instruction never stalls on its own write.
    assign thr       = i_id_early ? '0 : FWD_C;
    assign rs_haz    = i_id_use_rs && (i_id_rs != '0) && (cnt_q[i_id_rs] > thr);
    assign rt_haz    = i_id_use_rt && (i_id_rt != '0) && (cnt_q[i_id_rt] > thr);
    assign stall     = i_id_valid && (rs_haz || rt_haz);
    assign stall_out = stall && !i_halt;
    assign issue     = i_id_valid && !stall && !i_halt;

    assign o_stall_pc   = stall_out;
    assign o_stall_ifid = stall_out;
    assign o_bubble_ex  = stall_out;
    assign o_stall_cnt  = stall_cnt_q;

    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            cnt_d[n] = cnt_q[n];
            if (n == 0) begin
                cnt_d[n] = '0;
            end else if (i_halt) begin
                cnt_d[n] = cnt_q[n];
            end else if (i_kill) begin
                cnt_d[n] = '0;
            end else if (issue && i_id_wr_en && (i_id_rd == NB_REG_ADDR'(n))) begin
                cnt_d[n] = i_id_is_load ? LD_C : ALU_C;
            end else if (cnt_q[n] != '0) begin
                cnt_d[n] = cnt_q[n] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            o_busy[n] = (cnt_q[n] != '0);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NREG; n++) begin
                cnt_q[n] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int n = 0; n < NREG; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
